spi_sprite_loader: RTL

- Sits directly downstream of the SPI slave byte receiver inside main.
- Parses each chip-select-framed byte stream: command byte, sprite id, then SPRITE_BYTES pixel bytes.
- Emits one write strobe per pixel into the sprite RAM at address id*SPRITE_BYTES + index.
- Reports completion and framing errors to the status/LED logic.

---
 rtl/spi_sprite_loader_if.sv | 30 +++
 rtl/spi_sprite_loader.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/spi_sprite_loader_if.sv
// Byte-receiver-to-sprite-RAM bundle for spi_sprite_loader.
// The master side drives the SPI byte stream; the slave side drives the RAM write port and status.
interface spi_sprite_loader_if #(
    parameter int SPRITE_BYTES = 512,
    parameter int SPRITE_COUNT = 16
);
    localparam int ADDR_W = $clog2(SPRITE_COUNT * SPRITE_BYTES);
    localparam int ID_W   = $clog2(SPRITE_COUNT);

    logic              cs_active;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic              load_done;
    logic              err;
    logic [ID_W-1:0]   last_id;

    modport master (
        output cs_active, rx_valid, rx_data,
        input  wr_en, wr_addr, wr_data, busy, load_done, err, last_id
    );

    modport slave (
        input  cs_active, rx_valid, rx_data,
        output wr_en, wr_addr, wr_data, busy, load_done, err, last_id
    );
endinterface

// File: rtl/spi_sprite_loader.sv
// Parses CS-framed SPI byte streams (command, id, pixels) into sprite RAM writes.
// Define SPRITE_LOADER_CKSUM_EN to require a trailing XOR checksum byte before load_done.
module spi_sprite_loader #(
    parameter int         SPRITE_BYTES = 512,
    parameter int         SPRITE_COUNT = 16,
    parameter logic [7:0] CMD_LOAD     = 8'h00,
    parameter int         ADDR_W       = $clog2(SPRITE_COUNT * SPRITE_BYTES)
) (
    input  logic                 sys_clock,
    input  logic                 reset,
    spi_sprite_loader_if.slave   bus
);
    localparam int CNT_W = $clog2(SPRITE_BYTES);
    localparam int ID_W  = $clog2(SPRITE_COUNT);

    typedef enum logic [2:0] {IDLE, GET_ID, LOAD, DRAIN, IGNORE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              load_done_q, load_done_d;
    logic              err_q, err_d;
    logic [ID_W-1:0]   last_id_q, last_id_d;
`ifdef SPRITE_LOADER_CKSUM_EN
    logic [7:0]        cks_q, cks_d;
    logic              trl_seen_q, trl_seen_d;
`else
    logic              done_pend_q, done_pend_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        load_done_d = 1'b0;
        err_d       = 1'b0;
        last_id_d   = last_id_q;
`ifdef SPRITE_LOADER_CKSUM_EN
        cks_d       = cks_q;
        trl_seen_d  = trl_seen_q;
`else
        // Completion is reported one cycle after the final write strobe.
        done_pend_d = 1'b0;
        if (done_pend_q) begin
            load_done_d = 1'b1;
            last_id_d   = id_q;
        end
`endif

        // Chip-select release wins over any byte arriving in the same cycle.
        if (!bus.cs_active) begin
            if (state_q == LOAD)
                err_d = 1'b1;
`ifdef SPRITE_LOADER_CKSUM_EN
            if (state_q == DRAIN && !trl_seen_q)
                err_d = 1'b1;
`endif
            state_d = IDLE;
        end else if (bus.rx_valid) begin
            case (state_q)
                IDLE: state_d = (bus.rx_data == CMD_LOAD) ? GET_ID : IGNORE;
                GET_ID: begin
                    if (int'({24'd0, bus.rx_data}) < SPRITE_COUNT) begin
                        id_d    = ID_W'(bus.rx_data);
                        cnt_d   = '0;
                        state_d = LOAD;
`ifdef SPRITE_LOADER_CKSUM_EN
                        cks_d   = 8'h00;
`endif
                    end else begin
                        err_d   = 1'b1;
                        state_d = IGNORE;
                    end
                end
                LOAD: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ADDR_W'({id_q, cnt_q});
                    wr_data_d = bus.rx_data;
`ifdef SPRITE_LOADER_CKSUM_EN
                    cks_d     = cks_q ^ bus.rx_data;
`endif
                    if (cnt_q == CNT_W'(SPRITE_BYTES - 1)) begin
                        state_d     = DRAIN;
`ifdef SPRITE_LOADER_CKSUM_EN
                        trl_seen_d  = 1'b0;
`else
                        done_pend_d = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DRAIN: begin
`ifdef SPRITE_LOADER_CKSUM_EN
                    if (!trl_seen_q) begin
                        trl_seen_d = 1'b1;
                        if (bus.rx_data == cks_q) begin
                            load_done_d = 1'b1;
                            last_id_d   = id_q;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
`endif
                end
                default: ;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            id_q        <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'h00;
            busy_q      <= 1'b0;
            load_done_q <= 1'b0;
            err_q       <= 1'b0;
            last_id_q   <= '0;
`ifdef SPRITE_LOADER_CKSUM_EN
            cks_q       <= 8'h00;
            trl_seen_q  <= 1'b0;
`else
            done_pend_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
            load_done_q <= load_done_d;
            err_q       <= err_d;
            last_id_q   <= last_id_d;
`ifdef SPRITE_LOADER_CKSUM_EN
            cks_q       <= cks_d;
            trl_seen_q  <= trl_seen_d;
`else
            done_pend_q <= done_pend_d;
`endif
        end
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.busy      = busy_q;
    assign bus.load_done = load_done_q;
    assign bus.err       = err_q;
    assign bus.last_id   = last_id_q;
endmodule
